relax_scheduler: RTL and testbench

RELAX_SCHEDULER -- requirements
Module: relax_scheduler

---
 rtl/relax_scheduler_pkg.sv | 13 +
 rtl/relax_scheduler_one_hot_shift.sv | 18 +
 rtl/relax_scheduler.sv | 136 +++++++++++++
 tb/tb_relax_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/relax_scheduler_pkg.sv
// Shared definitions for the relaxation frame scheduler: FSM encoding and
// pass-counter width.
package relax_scheduler_pkg;

  localparam int unsigned ITER_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/relax_scheduler_one_hot_shift.sv
// Rotate-left-by-one of a one-hot vector; the MSB wraps back to bit 0, which
// is exactly the "return to 1" behaviour the sequencer needs after a commit.
module one_hot_shift #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] i_vec,
  output logic [W-1:0] o_vec
);

  generate
    if (W == 1) begin : g_single
      assign o_vec = i_vec;
    end else begin : g_rot
      assign o_vec = {i_vec[W-2:0], i_vec[W-1]};
    end
  endgenerate

endmodule

// File: rtl/relax_scheduler.sv
// Frame sequencer: walks node phases within each core, cores within each
// pass, and passes within a frame; latches mouse coordinates per frame.
module relax_scheduler
  import relax_scheduler_pkg::*;
#(
  parameter int unsigned NUM_CORES      = 4,
  parameter int unsigned NODES_PER_CORE = 5,
  parameter int unsigned ITERATIONS     = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_req,
  input  logic [31:0]             x_mouse_in,
  input  logic [31:0]             y_mouse_in,
  input  logic                    hold,
  input  logic                    overrun_clr,
  output logic                    frame_ack,
  output logic [31:0]             x_mouse,
  output logic [31:0]             y_mouse,
  output logic [NUM_CORES-1:0]    core_sel,
  output logic [NODES_PER_CORE:0] node_sel,
  output logic [ITER_W-1:0]       iter,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overrun
);

  localparam int unsigned       NODE_W    = NODES_PER_CORE + 1;
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(ITERATIONS - 1);

  state_t                r_state, w_state_nxt;
  logic [NUM_CORES-1:0]  r_core, w_core_nxt, w_core_rot;
  logic [NODE_W-1:0]     r_node, w_node_nxt, w_node_rot;
  logic [ITER_W-1:0]     r_iter, w_iter_nxt;
  logic [31:0]           r_x, w_x_nxt;
  logic [31:0]           r_y, w_y_nxt;
  logic                  r_ack, w_ack_nxt;
  logic                  r_overrun, w_overrun_nxt;

  one_hot_shift #(.W(NODE_W)) u_node_rot (
    .i_vec (r_node),
    .o_vec (w_node_rot)
  );

  one_hot_shift #(.W(NUM_CORES)) u_core_rot (
    .i_vec (r_core),
    .o_vec (w_core_rot)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_core    <= '0;
      r_node    <= '0;
      r_iter    <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_ack     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_core    <= w_core_nxt;
      r_node    <= w_node_nxt;
      r_iter    <= w_iter_nxt;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_ack     <= w_ack_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_core_nxt    = r_core;
    w_node_nxt    = r_node;
    w_iter_nxt    = r_iter;
    w_x_nxt       = r_x;
    w_y_nxt       = r_y;
    w_ack_nxt     = 1'b0;
    w_overrun_nxt = r_overrun;

    // Set is evaluated after clear so a simultaneous pair leaves the flag set.
    if (overrun_clr)
      w_overrun_nxt = 1'b0;
    if (frame_req && (r_state != ST_IDLE))
      w_overrun_nxt = 1'b1;

    case (r_state)
      ST_IDLE: begin
        if (frame_req) begin
          w_state_nxt = ST_UPDATE;
          w_core_nxt  = NUM_CORES'(1);
          w_node_nxt  = NODE_W'(1);
          w_iter_nxt  = '0;
          w_x_nxt     = x_mouse_in;
          w_y_nxt     = y_mouse_in;
          w_ack_nxt   = 1'b1;
        end
      end
      ST_UPDATE: begin
        if (!hold) begin
          w_node_nxt = w_node_rot;
          if (r_node[NODE_W-1]) begin
            w_core_nxt = w_core_rot;
            if (r_core[NUM_CORES-1]) begin
              if (r_iter == ITER_LAST) begin
                w_state_nxt = ST_DONE;
                w_core_nxt  = '0;
                w_node_nxt  = '0;
              end else begin
                w_iter_nxt = r_iter + 1'b1;
              end
            end
          end
        end
      end
      ST_DONE: begin
        if (!hold)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign frame_ack  = r_ack;
  assign x_mouse    = r_x;
  assign y_mouse    = r_y;
  assign core_sel   = r_core;
  assign node_sel   = r_node;
  assign iter       = r_iter;
  assign busy       = (r_state != ST_IDLE);
  // A held DONE cycle withholds the pulse until the cycle that actually leaves DONE.
  assign frame_done = (r_state == ST_DONE) && !hold;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_relax_scheduler.sv
// Directed bench for relax_scheduler: default-size instance plus a minimal
// ITERATIONS=1 / NUM_CORES=1 instance.
module tb_relax_scheduler;

  logic clk = 1'b0;
  logic reset;

  logic        req_a, hold_a, oclr_a;
  logic [31:0] xin_a, yin_a;
  logic        ack_a, busy_a, done_a, ovr_a;
  logic [31:0] x_a, y_a;
  logic [3:0]  core_a;
  logic [5:0]  node_a;
  logic [7:0]  iter_a;

  logic        req_b, hold_b, oclr_b;
  logic [31:0] xin_b, yin_b;
  logic        ack_b, busy_b, done_b, ovr_b;
  logic [31:0] x_b, y_b;
  logic [0:0]  core_b;
  logic [5:0]  node_b;
  logic [7:0]  iter_b;

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  relax_scheduler u_dut_a (
    .clk         (clk),
    .reset       (reset),
    .frame_req   (req_a),
    .x_mouse_in  (xin_a),
    .y_mouse_in  (yin_a),
    .hold        (hold_a),
    .overrun_clr (oclr_a),
    .frame_ack   (ack_a),
    .x_mouse     (x_a),
    .y_mouse     (y_a),
    .core_sel    (core_a),
    .node_sel    (node_a),
    .iter        (iter_a),
    .busy        (busy_a),
    .frame_done  (done_a),
    .overrun     (ovr_a)
  );

  relax_scheduler #(
    .NUM_CORES      (1),
    .NODES_PER_CORE (5),
    .ITERATIONS     (1)
  ) u_dut_b (
    .clk         (clk),
    .reset       (reset),
    .frame_req   (req_b),
    .x_mouse_in  (xin_b),
    .y_mouse_in  (yin_b),
    .hold        (hold_b),
    .overrun_clr (oclr_b),
    .frame_ack   (ack_b),
    .x_mouse     (x_b),
    .y_mouse     (y_b),
    .core_sel    (core_b),
    .node_sel    (node_b),
    .iter        (iter_b),
    .busy        (busy_b),
    .frame_done  (done_b),
    .overrun     (ovr_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic adv(input int n);
    while (cyc < n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input bit sel, input int limit, input int exp_cyc);
    while (!(sel ? done_b : done_a) && cyc < limit) tick();
    chk(sel ? "b_done_cycle" : "a_done_cycle", cyc, exp_cyc);
  endtask

  task automatic start_a(input logic [31:0] x, input logic [31:0] y);
    xin_a = x;
    yin_a = y;
    req_a = 1'b1;
    cyc   = 0;
    tick();
    req_a = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int nd;
    reset  = 1'b1;
    req_a  = 1'b0; hold_a = 1'b0; oclr_a = 1'b0; xin_a = '0; yin_a = '0;
    req_b  = 1'b0; hold_b = 1'b0; oclr_b = 1'b0; xin_b = '0; yin_b = '0;
    tick(); tick();

    // Reset state
    chk("rst_core",  core_a, 0);
    chk("rst_node",  node_a, 0);
    chk("rst_iter",  iter_a, 0);
    chk("rst_busy",  busy_a, 0);
    chk("rst_ack",   ack_a,  0);
    chk("rst_done",  done_a, 0);
    chk("rst_ovr",   ovr_a,  0);
    chk("rst_x",     x_a,    0);
    reset = 1'b0;
    tick();

    // Basic frame with node/core trace
    start_a(32'h10, 32'h20);
    chk("t1_ack",  ack_a,  1);
    chk("t1_x",    x_a,    32'h10);
    chk("t1_y",    y_a,    32'h20);
    chk("t1_busy", busy_a, 1);
    chk("t1_iter", iter_a, 0);
    for (int c = 1; c <= 12; c++) begin
      p = c - 1;
      chk("t2_node", node_a, 32'(1 << (p % 6)));
      chk("t2_core", core_a, 32'(1 << (p / 6)));
      if (cyc == 2) chk("t1_ack_pulse", ack_a, 0);
      tick();
    end
    adv(24);
    chk("t1_iter24", iter_a, 0);
    chk("t1_commit", node_a, 32);
    chk("t1_core24", core_a, 8);
    tick();
    chk("t1_iter25", iter_a, 1);
    chk("t1_node25", node_a, 1);
    chk("t1_core25", core_a, 1);
    adv(192);
    chk("t1_last_node", node_a, 32);
    chk("t1_last_iter", iter_a, 7);
    chk("t1_done_early", done_a, 0);
    wait_done(1'b0, 400, 193);
    chk("t1_busy_done", busy_a, 1);
    chk("t1_core_done", core_a, 0);
    tick();
    chk("t1_busy_idle", busy_a, 0);
    chk("t1_done_pulse", done_a, 0);

    // Hold for 10 cycles from cycle 50
    start_a(32'h11, 32'h22);
    adv(50);
    hold_a = 1'b1;
    chk("t3_node50", node_a, 2);
    chk("t3_core50", core_a, 1);
    chk("t3_iter50", iter_a, 2);
    adv(55);
    chk("t3_node55", node_a, 2);
    adv(60);
    hold_a = 1'b0;
    chk("t3_node60", node_a, 2);
    chk("t3_iter60", iter_a, 2);
    chk("t3_busy60", busy_a, 1);
    tick();
    chk("t3_node61", node_a, 4);
    wait_done(1'b0, 400, 203);
    tick();

    // Overrun while busy
    start_a(32'h33, 32'h44);
    adv(30);
    req_a = 1'b1;
    xin_a = 32'h99;
    tick();
    req_a = 1'b0;
    chk("t4_no_ack", ack_a, 0);
    chk("t4_ovr",    ovr_a, 1);
    chk("t4_x_keep", x_a,   32'h33);
    adv(35);
    chk("t4_ovr35", ovr_a, 1);
    adv(40);
    oclr_a = 1'b1;
    tick();
    oclr_a = 1'b0;
    chk("t4_ovr_clr", ovr_a, 0);
    adv(45);
    oclr_a = 1'b1;
    req_a  = 1'b1;
    tick();
    oclr_a = 1'b0;
    req_a  = 1'b0;
    chk("t4_ovr_both", ovr_a, 1);
    chk("t4_no_ack2",  ack_a, 0);
    adv(50);
    oclr_a = 1'b1;
    tick();
    oclr_a = 1'b0;
    chk("t4_ovr_clr2", ovr_a, 0);
    wait_done(1'b0, 400, 193);
    chk("t4_x_done", x_a, 32'h33);
    tick();

    // Asynchronous reset mid-frame
    start_a(32'h55, 32'h56);
    adv(100);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_core", core_a, 0);
    chk("t5_node", node_a, 0);
    chk("t5_iter", iter_a, 0);
    chk("t5_busy", busy_a, 0);
    chk("t5_x",    x_a,    0);
    chk("t5_done", done_a, 0);
    tick();
    tick();
    reset = 1'b0;
    nd = 0;
    repeat (30) begin
      tick();
      if (done_a) nd++;
    end
    chk("t5_no_done", nd, 0);
    chk("t5_idle", busy_a, 0);
    start_a(32'h66, 32'h67);
    chk("t5_ack",   ack_a,  1);
    chk("t5_iter0", iter_a, 0);
    chk("t5_node1", node_a, 1);
    chk("t5_x_new", x_a,    32'h66);
    wait_done(1'b0, 400, 193);
    tick();
    chk("t5_idle2", busy_a, 0);

    // Minimal instance: one core, one pass
    xin_b = 32'h77;
    yin_b = 32'h78;
    req_b = 1'b1;
    cyc   = 0;
    tick();
    req_b = 1'b0;
    chk("t6_ack",  ack_b,  1);
    chk("t6_x",    x_b,    32'h77);
    chk("t6_node", node_b, 1);
    chk("t6_core", core_b, 1);
    adv(3);
    xin_b = 32'hAB;
    adv(6);
    chk("t6_commit", node_b, 32);
    chk("t6_iter",   iter_b, 0);
    wait_done(1'b1, 50, 7);
    chk("t6_x_keep", x_b, 32'h77);
    tick();
    chk("t6_idle", busy_b, 0);

    // Hold while in DONE on the minimal instance
    xin_b = 32'hC0;
    req_b = 1'b1;
    cyc   = 0;
    tick();
    req_b = 1'b0;
    adv(7);
    hold_b = 1'b1;
    #1;
    chk("t7_done_held", done_b, 0);
    chk("t7_busy_held", busy_b, 1);
    tick();
    chk("t7_done_held8", done_b, 0);
    chk("t7_busy_held8", busy_b, 1);
    tick();
    hold_b = 1'b0;
    #1;
    chk("t7_done_rel", done_b, 1);
    tick();
    chk("t7_idle", busy_b, 0);
    chk("t7_done_off", done_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
